read_buf_stream_adapter: RTL and testbench
==========================================

Name: read_buf_stream_adapter

Overview:
- Sits directly downstream of read_ahead_buf and consumes its show-ahead read interface: data valid whenever empty is low, popped by r_req.
- Re-presents that data as a fully registered valid/ready stream for downstream datapath blocks.
- Contains a 2-entry skid buffer, so neither the output data nor the upstream pop depends combinationally on downstream ready.

Parameters:
- DATA_W, 16, width of data words, upstream and downstream.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- buf_r_req  output  1  pop strobe to read_ahead_buf (its r_req).
- buf_r_data  input  DATA_W  head word from read_ahead_buf; valid while buf_empty==0.
- buf_empty  input  1  read_ahead_buf empty flag.
- flush  input  1  synchronous clear of both held entries.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream accepts the word this cycle.
- out_data  output  DATA_W  registered output word.
- cnt  output  2  number of words held (0..2).

Behaviour:
- Reset: async on rst high; out_valid=0, out_data=0, skid entry=0, cnt=0, buf_r_req=0 (combinational, forced low while rst high).
- Storage: main register (drives out_data/out_valid) plus skid register. cnt encodes state: S0 (0 words), S1 (main only), S2 (main+skid). cnt==3 never occurs.
- Upstream pop: buf_r_req = ~buf_empty & (cnt!=2) & ~flush & ~rst. It never depends on out_ready. It is never asserted while buf_empty=1.
- Downstream transfer: xfer = out_valid & out_ready. out_data must stay stable while out_valid=1 and out_ready=0.
- Transitions (pop = buf_r_req):
  - S0: pop -> main<=buf_r_data, S1. No pop -> stay S0.
  - S1: pop & xfer -> main<=buf_r_data, stay S1. pop & ~xfer -> skid<=buf_r_data, S2. ~pop & xfer -> S0. Neither -> hold.
  - S2: no pop possible. xfer -> main<=skid, S1. No xfer -> hold.
- Latency: a word popped in cycle N is visible on out_data in cycle N+1 if S0 or (S1 with xfer) held in N. Otherwise it is queued behind main.
- Ordering: strict FIFO. No word is lost, duplicated, or reordered.
- Throughput: 1 word/cycle sustained when buf_empty=0 and out_ready=1.
- Flush:
  - Next state S0, out_valid=0. out_data keeps its last value (don't-care).
  - A transfer occurring in the flush cycle still counts as completed downstream.
  - No pop in the flush cycle.
- Reset mid-operation: all held words are discarded immediately and asynchronously. The upstream FIFO is not affected by this block.
- out_ready while out_valid=0 is ignored.

Optional Feature:
- Macro: READ_BUF_STREAM_STAT_EN.
- With the macro defined, two extra outputs exist:
  - xfer_cnt[31:0]: increments on every xfer, wraps 0xFFFFFFFF->0.
  - stall_cnt[31:0]: increments each cycle out_valid=1 & out_ready=0, wraps.
  - Both clear on rst and on flush.
- Without the macro: neither port nor any counter logic exists; behaviour is otherwise identical.

Test Plan:
- Reset then upstream holds 0x1111,0x2222,0x3333 with out_ready=1 -> buf_r_req high 3 consecutive cycles; out_data 0x1111,0x2222,0x3333 on cycles 1,2,3 after first pop; cnt returns to 0.
- 2 words available, out_ready=0 -> exactly 2 pops, cnt=2, buf_r_req=0 while buf_empty=0; out_data=first word stable; release ready -> both delivered in order, then next pops resume.
- Random buf_empty and out_ready (16-bit random data, 10000 cycles) against a scoreboard queue -> delivered sequence equals popped sequence; cnt never 3; no pop while buf_empty=1.
- cnt=2, assert flush 1 cycle with out_ready=1 -> out_valid=0 next cycle, cnt=0, no pop in flush cycle, next buf word 0xABCD is the first delivered afterwards.
- rst pulsed asynchronously mid-burst at cnt=1 -> out_valid=0 and cnt=0 immediately; after release, stream resumes from the current upstream head.
- With READ_BUF_STREAM_STAT_EN: 5 transfers and 3 stall cycles -> xfer_cnt=5, stall_cnt=3; flush -> both 0.

Source files
------------

// File: rtl/read_buf_stream_adapter.sv
// Show-ahead FIFO read port to registered valid/ready stream, 2-entry skid buffer.
// Latency: a popped word appears on out_data the next cycle when main is free or draining.
// Backpressure: pop depends only on held count, never on out_ready; full (cnt==2) stops popping.
// Optional statistics counters: define READ_BUF_STREAM_STAT_EN.
module read_buf_stream_adapter #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              buf_r_req,
  input  logic [DATA_W-1:0] buf_r_data,
  input  logic              buf_empty,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        cnt
`ifdef READ_BUF_STREAM_STAT_EN
  ,
  output logic [31:0]       xfer_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  // Held-word count doubles as the state: S0 empty, S1 main only, S2 main+skid.
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_q;
  logic [DATA_W-1:0] skid_d;
  logic              valid_d;
  logic              pop;
  logic              xfer;

  // Reset gates the pop combinationally so nothing leaves upstream while we are cleared.
  assign pop       = ~buf_empty & (state_q != S2) & ~flush & ~rst;
  assign buf_r_req = pop;
  assign xfer      = out_valid & out_ready;
  assign cnt       = state_q;

  // Next-state and next-data selection for the main/skid pair.
  always_comb begin
    state_d = state_q;
    main_d  = out_data;
    skid_d  = skid_q;
    case (state_q)
      S0: begin
        if (pop) begin
          main_d  = buf_r_data;
          state_d = S1;
        end
      end
      S1: begin
        if (pop && xfer) begin
          main_d = buf_r_data;
        end else if (pop) begin
          skid_d  = buf_r_data;
          state_d = S2;
        end else if (xfer) begin
          state_d = S0;
        end
      end
      S2: begin
        if (xfer) begin
          main_d  = skid_q;
          state_d = S1;
        end
      end
      default: state_d = S0;
    endcase
    // Flush drops both entries; out_data simply keeps its last value.
    if (flush) begin
      state_d = S0;
      main_d  = out_data;
      skid_d  = skid_q;
    end
    valid_d = (state_d != S0);
  end

  // State, output and skid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S0;
      out_data  <= '0;
      out_valid <= 1'b0;
      skid_q    <= '0;
    end else begin
      state_q   <= state_d;
      out_data  <= main_d;
      out_valid <= valid_d;
      skid_q    <= skid_d;
    end
  end

`ifdef READ_BUF_STREAM_STAT_EN
  // Transfer and stall counters; flush restarts both, wrap naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt  <= '0;
      stall_cnt <= '0;
    end else if (flush) begin
      xfer_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (xfer) xfer_cnt <= xfer_cnt + 32'd1;
      if (out_valid && !out_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_read_buf_stream_adapter.sv
// Directed and randomized bench for read_buf_stream_adapter.
// Upstream is a queue standing in for read_ahead_buf; a scoreboard tracks popped words.
// Inputs change 1ns after the rising edge; outputs are checked 2ns after it.
module tb_read_buf_stream_adapter;

  logic        clk;
  logic        rst;
  logic        buf_r_req;
  logic [15:0] buf_r_data;
  logic        buf_empty;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  cnt;
`ifdef READ_BUF_STREAM_STAT_EN
  logic [31:0] xfer_cnt;
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] upq[$];
  logic [15:0] sb[$];
  logic hide = 1'b0;

  read_buf_stream_adapter #(.DATA_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .buf_r_req(buf_r_req),
    .buf_r_data(buf_r_data),
    .buf_empty(buf_empty),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .cnt(cnt)
`ifdef READ_BUF_STREAM_STAT_EN
    ,
    .xfer_cnt(xfer_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_up();
    buf_empty  = (upq.size() == 0) || hide;
    buf_r_data = (upq.size() != 0) ? upq[0] : 16'h0000;
  endtask

  // One clock: pop/transfer decided by pre-edge values, scoreboard checks deliveries.
  task automatic tick();
    logic p;
    logic x;
    logic [15:0] d;
    logic [15:0] e;
    p = buf_r_req;
    x = out_valid & out_ready;
    d = out_data;
    @(posedge clk);
    #1;
    if (x) begin
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("deliver_order", {16'h0, d}, {16'h0, e});
      end else begin
        check("deliver_unexpected", 32'd1, 32'd0);
      end
    end
    if (p && upq.size() != 0) begin
      sb.push_back(upq[0]);
      void'(upq.pop_front());
    end
    drive_up();
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((upq.size() != 0 || cnt != 2'd0) && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_drain_bounded"}, {31'h0, n < 100}, 32'd1);
    check({tag, "_drain_sb_empty"}, sb.size(), 32'd0);
  endtask

  initial begin
    // ---------------- reset state ----------------
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    upq = '{16'h1111, 16'h2222, 16'h3333};
    drive_up();
    #1;
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_cnt", {30'h0, cnt}, 32'd0);
    check("rst_out_data", {16'h0, out_data}, 32'h0);
    check("rst_req_forced_low", {31'h0, buf_r_req}, 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;

    // ---------------- streaming, ready high ----------------
    check("t1_req_c0", {31'h0, buf_r_req}, 32'd1);
    tick();
    check("t1_data_c1", {16'h0, out_data}, 32'h1111);
    check("t1_valid_c1", {31'h0, out_valid}, 32'd1);
    check("t1_req_c1", {31'h0, buf_r_req}, 32'd1);
    tick();
    check("t1_data_c2", {16'h0, out_data}, 32'h2222);
    check("t1_req_c2", {31'h0, buf_r_req}, 32'd1);
    tick();
    check("t1_data_c3", {16'h0, out_data}, 32'h3333);
    check("t1_cnt_c3", {30'h0, cnt}, 32'd1);
    check("t1_req_c3", {31'h0, buf_r_req}, 32'd0);
    tick();
    check("t1_cnt_end", {30'h0, cnt}, 32'd0);
    check("t1_valid_end", {31'h0, out_valid}, 32'd0);

    // ---------------- backpressure fills skid ----------------
    out_ready = 1'b0;
    upq = '{16'h4444, 16'h5555, 16'h6666};
    drive_up();
    #1;
    check("t2_req_c0", {31'h0, buf_r_req}, 32'd1);
    tick();
    check("t2_cnt_c1", {30'h0, cnt}, 32'd1);
    check("t2_data_c1", {16'h0, out_data}, 32'h4444);
    check("t2_req_c1", {31'h0, buf_r_req}, 32'd1);
    tick();
    check("t2_cnt_full", {30'h0, cnt}, 32'd2);
    check("t2_req_full", {31'h0, buf_r_req}, 32'd0);
    check("t2_empty_low", {31'h0, buf_empty}, 32'd0);
    check("t2_data_hold", {16'h0, out_data}, 32'h4444);
    tick();
    check("t2_data_stable", {16'h0, out_data}, 32'h4444);
    check("t2_cnt_stable", {30'h0, cnt}, 32'd2);
    check("t2_head_unpopped", {16'h0, buf_r_data}, 32'h6666);
    out_ready = 1'b1;
    #1;
    tick();
    check("t2_data_second", {16'h0, out_data}, 32'h5555);
    check("t2_cnt_after_skid", {30'h0, cnt}, 32'd1);
    check("t2_req_resume", {31'h0, buf_r_req}, 32'd1);
    tick();
    check("t2_data_third", {16'h0, out_data}, 32'h6666);
    tick();
    check("t2_cnt_end", {30'h0, cnt}, 32'd0);

    // ---------------- flush at cnt=2 ----------------
    out_ready = 1'b0;
    upq = '{16'h7777, 16'h8888, 16'hABCD};
    drive_up();
    #1;
    tick();
    tick();
    check("t4_cnt_full", {30'h0, cnt}, 32'd2);
    out_ready = 1'b1;
    flush = 1'b1;
    #1;
    check("t4_no_pop_flush", {31'h0, buf_r_req}, 32'd0);
    tick();
    sb.delete();
    check("t4_valid_after", {31'h0, out_valid}, 32'd0);
    check("t4_cnt_after", {30'h0, cnt}, 32'd0);
    check("t4_head_kept", {16'h0, buf_r_data}, 32'hABCD);
    flush = 1'b0;
    #1;
    tick();
    check("t4_first_after", {16'h0, out_data}, 32'hABCD);
    check("t4_valid_first", {31'h0, out_valid}, 32'd1);
    tick();
    check("t4_cnt_end", {30'h0, cnt}, 32'd0);

    // ---------------- async reset mid-burst ----------------
    upq = '{16'h1234, 16'h5678, 16'h9ABC};
    drive_up();
    #1;
    tick();
    check("t5_cnt_one", {30'h0, cnt}, 32'd1);
    check("t5_data_one", {16'h0, out_data}, 32'h1234);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", {31'h0, out_valid}, 32'd0);
    check("t5_rst_cnt", {30'h0, cnt}, 32'd0);
    check("t5_rst_req", {31'h0, buf_r_req}, 32'd0);
    tick();
    sb.delete();
    rst = 1'b0;
    #1;
    check("t5_head", {16'h0, buf_r_data}, 32'h5678);
    check("t5_req_resume", {31'h0, buf_r_req}, 32'd1);
    tick();
    check("t5_data_resume", {16'h0, out_data}, 32'h5678);
    tick();
    check("t5_data_next", {16'h0, out_data}, 32'h9ABC);
    tick();
    check("t5_cnt_end", {30'h0, cnt}, 32'd0);

    // ---------------- random traffic vs scoreboard ----------------
    for (int i = 0; i < 10000; i++) begin
      if (upq.size() < 4) upq.push_back(16'($urandom));
      hide = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      drive_up();
      #1;
      if (cnt == 2'd3) check("rnd_cnt_not3", {30'h0, cnt}, 32'd0);
      if (buf_r_req && buf_empty) check("rnd_pop_while_empty", 32'd1, 32'd0);
      if (cnt == 2'd2 && buf_r_req) check("rnd_pop_when_full", 32'd1, 32'd0);
      tick();
    end
    hide = 1'b0;
    out_ready = 1'b1;
    drive_up();
    #1;
    drain("rnd");

`ifdef READ_BUF_STREAM_STAT_EN
    // ---------------- statistics counters ----------------
    flush = 1'b1;
    #1;
    tick();
    flush = 1'b0;
    check("st_xfer_clr0", xfer_cnt, 32'd0);
    check("st_stall_clr0", stall_cnt, 32'd0);
    out_ready = 1'b0;
    upq = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
    drive_up();
    #1;
    tick();
    tick();
    tick();
    tick();
    check("st_stall_mid", stall_cnt, 32'd3);
    out_ready = 1'b1;
    #1;
    drain("st");
    check("st_xfer", xfer_cnt, 32'd5);
    check("st_stall", stall_cnt, 32'd3);
    flush = 1'b1;
    #1;
    tick();
    flush = 1'b0;
    check("st_xfer_flush", xfer_cnt, 32'd0);
    check("st_stall_flush", stall_cnt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
